// File: rtl/moving_avg_filter.sv
// Streaming moving-average filter over a 2**LOG2_DEPTH sample window.
// A running sum is updated per accepted sample and divided by an arithmetic shift.
module moving_avg_filter #(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         clear,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [DATA_W+LOG2_DEPTH-1:0] sum_out,
  output logic                         full
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int SW    = DATA_W + LOG2_DEPTH;

  localparam logic [LOG2_DEPTH:0]  LAST_FILL = (LOG2_DEPTH + 1)'(DEPTH - 1);
  localparam logic signed [SW:0]   AVG_MAX   = (SW + 1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW:0]   HALF      = (SW + 1)'(DEPTH / 2);

  typedef enum logic {FILL, RUN} state_t;

  logic [DATA_W-1:0]     win [DEPTH];
  logic [LOG2_DEPTH-1:0] ptr;
  logic [LOG2_DEPTH:0]   fill_cnt;
  state_t                state;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  sum_next;
  logic signed [SW:0]    rsum;
  logic signed [SW:0]    rdiv;
  logic [DATA_W-1:0]     avg;

  // The widened sum can never overflow, so the floor average is simply its top DATA_W bits.
  always_comb begin
    sum_next = sum
             + $signed({{LOG2_DEPTH{in_data[DATA_W-1]}}, in_data})
             - $signed({{LOG2_DEPTH{win[ptr][DATA_W-1]}}, win[ptr]});
    rsum = $signed({sum_next[SW-1], sum_next}) + HALF;
    rdiv = rsum >>> LOG2_DEPTH;
    if (ROUND == 0)
      avg = sum_next[SW-1:LOG2_DEPTH];
    else if (rdiv > AVG_MAX)
      avg = AVG_MAX[DATA_W-1:0];
    else
      avg = rdiv[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      ptr       <= '0;
      fill_cnt  <= '0;
      state     <= FILL;
      sum       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sum_out   <= '0;
      full      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        ptr      <= '0;
        fill_cnt <= '0;
        state    <= FILL;
        sum      <= '0;
        out_data <= '0;
        sum_out  <= '0;
        full     <= 1'b0;
      end else if (in_valid) begin
        win[ptr]  <= in_data;
        ptr       <= ptr + 1'b1;
        sum       <= sum_next;
        out_valid <= 1'b1;
        out_data  <= avg;
        sum_out   <= sum_next;
        // full rises together with the output of the DEPTH-th sample.
        case (state)
          FILL: begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == LAST_FILL) begin
              state <= RUN;
              full  <= 1'b1;
            end
          end
          RUN: ;
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Bench for moving_avg_filter: a floor and a rounding instance share one stimulus stream,
// checked against fixed vectors and a queue-based window model.
module tb_moving_avg_filter;
  localparam int DATA_W = 8;
  localparam int LOG2_DEPTH = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic clear = 1'b0;
  logic valid0, valid1, full0, full1;
  logic [DATA_W-1:0] data0, data1;
  logic [DATA_W+LOG2_DEPTH-1:0] sum0, sum1;

  int total = 0;
  int passed = 0;

  moving_avg_filter #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(valid0), .out_data(data0), .sum_out(sum0), .full(full0));

  moving_avg_filter #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(valid1), .out_data(data1), .sum_out(sum1), .full(full1));

  always #5 clk = ~clk;

  // Reference model: the last DEPTH samples kept as plain integers.
  int  mq[$];
  int  msum, mcnt, mavg0, mavg1;
  bit  mvalid, mfull;

  function automatic int floordiv(int a, int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  task automatic modelReset();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(0);
    msum = 0; mcnt = 0; mavg0 = 0; mavg1 = 0; mvalid = 0; mfull = 0;
  endtask

  task automatic modelStep(input bit v, input int d, input bit c);
    if (c) begin
      modelReset();
    end else if (v) begin
      mq.push_back(d);
      void'(mq.pop_front());
      msum = 0;
      foreach (mq[i]) msum += mq[i];
      mcnt++;
      mfull = (mcnt >= DEPTH);
      mvalid = 1;
      mavg0 = floordiv(msum, DEPTH);
      mavg1 = floordiv(msum + DEPTH / 2, DEPTH);
      if (mavg1 > 127) mavg1 = 127;
    end else begin
      mvalid = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput();
    check("valid_floor", int'(valid0), int'(mvalid));
    check("valid_round", int'(valid1), int'(mvalid));
    check("sum_floor", int'($signed(sum0)), msum);
    check("sum_round", int'($signed(sum1)), msum);
    check("avg_floor", int'($signed(data0)), mavg0);
    check("avg_round", int'($signed(data1)), mavg1);
    check("full_floor", int'(full0), int'(mfull));
    check("full_round", int'(full1), int'(mfull));
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit c);
    in_valid = v;
    in_data  = d[DATA_W-1:0];
    clear    = c;
    @(posedge clk);
    #1;
    modelStep(v, d, c);
    checkOutput();
  endtask

  task automatic checkAllZero(input string name);
    check({name, "_valid"}, int'(valid0) + int'(valid1), 0);
    check({name, "_sum"}, int'(sum0) + int'(sum1), 0);
    check({name, "_data"}, int'(data0) + int'(data1), 0);
    check({name, "_full"}, int'(full0) + int'(full1), 0);
  endtask

  task automatic resetDut();
    in_valid = 0; clear = 0; in_data = '0;
    @(negedge clk);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 0;
    modelReset();
  endtask

  typedef struct {
    bit v; int d; bit c;
    bit evalid; int esum; int eavg; bit efull;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, int d, bit c, bit ev, int es, int ea, bit ef);
    vec_t t;
    t.v = v; t.d = d; t.c = c; t.evalid = ev; t.esum = es; t.eavg = ea; t.efull = ef;
    return t;
  endfunction

  task automatic runTable(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("tbl%0d_valid", i), int'(valid0), int'(tbl[i].evalid));
      check($sformatf("tbl%0d_sum", i), int'($signed(sum0)), tbl[i].esum);
      check($sformatf("tbl%0d_avg", i), int'($signed(data0)), tbl[i].eavg);
      check($sformatf("tbl%0d_full", i), int'(full0), int'(tbl[i].efull));
    end
  endtask

  initial begin
    // Ramp
    tbl.push_back(mk(1, 4, 0, 1, 4, 1, 0));
    tbl.push_back(mk(1, 8, 0, 1, 12, 3, 0));
    tbl.push_back(mk(1, 12, 0, 1, 24, 6, 0));
    tbl.push_back(mk(1, 16, 0, 1, 40, 10, 1));
    tbl.push_back(mk(1, 20, 0, 1, 56, 14, 1));
    // Extremes
    tbl.push_back(mk(1, -128, 0, 1, -80, -20, 1));
    tbl.push_back(mk(1, -128, 0, 1, -220, -55, 1));
    tbl.push_back(mk(1, -128, 0, 1, -364, -91, 1));
    tbl.push_back(mk(1, -128, 0, 1, -512, -128, 1));
    tbl.push_back(mk(1, 127, 0, 1, -257, -65, 1));
    tbl.push_back(mk(1, 127, 0, 1, -2, -1, 1));
    tbl.push_back(mk(1, 127, 0, 1, 253, 63, 1));
    tbl.push_back(mk(1, 127, 0, 1, 508, 127, 1));
    // Clear, then gaps and pointer wrap
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 10, 0, 1, 10, 2, 0));
    tbl.push_back(mk(0, 99, 0, 0, 10, 2, 0));
    tbl.push_back(mk(1, 20, 0, 1, 30, 7, 0));
    tbl.push_back(mk(1, 30, 0, 1, 60, 15, 0));
    tbl.push_back(mk(0, 77, 0, 0, 60, 15, 0));
    tbl.push_back(mk(1, 40, 0, 1, 100, 25, 1));
    tbl.push_back(mk(1, 50, 0, 1, 140, 35, 1));
    // Clear colliding with a sample
    tbl.push_back(mk(1, 100, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 0, 1, 8, 2, 0));

    modelReset();
    resetDut();
    runTable(0, tbl.size() - 1);

    // Rounding corner cases from reset
    resetDut();
    applyStimulus(1, -1, 0);
    check("round_neg1_floor", int'($signed(data0)), -1);
    check("round_neg1_round", int'($signed(data1)), 0);
    resetDut();
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    check("round_ones_sum", int'($signed(sum1)), 2);
    check("round_ones_floor", int'($signed(data0)), 0);
    check("round_ones_round", int'($signed(data1)), 1);

    // Randomised stream against the model
    resetDut();
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
                    $urandom_range(0, 40) == 0);

    // Asynchronous reset between edges while streaming
    in_valid = 1; in_data = 8'd55; clear = 0;
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    checkAllZero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    rst = 0;
    modelReset();
    runTable(0, 4);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/moving_avg_filter.md
Name: moving_avg_filter

Overview:
- Parametrised streaming moving-average filter over a window of 2**LOG2_DEPTH signed samples.
- Keeps a running sum: on each accepted sample, the new sample is added and the oldest is subtracted.
- The sum is divided by the window size with an arithmetic shift, so no divider is needed.
- Generalises the fixed 8-bit, sign-extended 10-bit adder path of the moving-average datapath to any data width and depth, and adds a valid handshake, a fill status flag, flush, and selectable rounding.

Parameters:
- DATA_W, 8, sample width in bits, two's complement.
- LOG2_DEPTH, 2, log2 of the window length; DEPTH = 2**LOG2_DEPTH, LOG2_DEPTH >= 1.
- ROUND, 0, division mode: 0 = floor (truncate toward -inf), 1 = round half up (add DEPTH/2 before the shift).

Ports:
- clk, input, 1, single system clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, in_data holds a sample to accept this cycle.
- in_data, input, DATA_W, signed input sample.
- clear, input, 1, synchronous flush of the window.
- out_valid, output, 1, out_data and sum_out are new this cycle.
- out_data, output, DATA_W, signed window average.
- sum_out, output, DATA_W+LOG2_DEPTH, signed running sum.
- full, output, 1, window holds DEPTH real samples since the last reset or clear.

Behaviour:
- Reset (asynchronous, rst=1): all window registers = 0, running sum = 0, write pointer = 0, fill count = 0, state = FILL, out_valid = 0, out_data = 0, sum_out = 0, full = 0. All registers stay in this state while rst is high.
- Storage:
  - Window is a circular register array of DEPTH x DATA_W, with a write pointer of LOG2_DEPTH bits.
  - The pointer addresses the oldest entry and wraps from DEPTH-1 to 0 with no special case.
- Accept (in_valid=1, clear=0):
  - sum_next = sum + sext(in_data) - sext(win[ptr]), with sign extension to DATA_W+LOG2_DEPTH bits.
  - win[ptr] <= in_data; ptr <= ptr+1.
- Sum width: DATA_W+LOG2_DEPTH bits holds every possible window sum. The sum must never overflow or saturate.
- Average:
  - ROUND=0: out_data = sum_next >>> LOG2_DEPTH.
  - ROUND=1: out_data = (sum_next + DEPTH/2) >>> LOG2_DEPTH, computed with one guard bit. If the result exceeds the maximum positive DATA_W value, it saturates to that value.
  - In both modes only the low DATA_W bits are output, and the result always fits.
- Latency:
  - out_valid, out_data and sum_out are registered one cycle after the accepting edge.
  - out_valid = 1 for exactly one cycle per accepted sample, and is 0 in cycles with no accept.
  - out_data and sum_out hold their last values while out_valid = 0.
- Warm-up: during FILL, the empty slots count as 0 and the sum is still divided by DEPTH. The output ramps up; it is not a partial-window mean.
- Fill state machine:
  - FILL: the fill counter increments on each accept. When the DEPTH-th sample is accepted, move to RUN and set full = 1 on the same edge as that sample's output.
  - RUN: full stays 1 and the fill counter is frozen.
- clear=1 (synchronous):
  - Window, sum, pointer and fill count go to 0; state = FILL; full = 0; out_valid = 0 next cycle.
  - out_data and sum_out are zeroed.
  - If in_valid is high in the same cycle, clear has priority and the sample is discarded.
- Backpressure: none. Every in_valid sample is accepted, including back-to-back every cycle at full throughput.
- in_data is ignored when in_valid = 0.

Test Plan:
- Ramp (DATA_W=8, LOG2_DEPTH=2, ROUND=0): after reset, feed 4, 8, 12, 16, 20 on consecutive cycles.
  - sum_out = 4, 12, 24, 40, 56.
  - out_data = 1, 3, 6, 10, 14.
  - full first rises with the 40/10 output; each output arrives one cycle after its input.
- Extremes:
  - Feed -128 four times: sum_out = -512 (0x200 in 10 bits), out_data = -128.
  - Then feed 127 four times: the final output has sum_out = 508, out_data = 127, and no wrap occurs at any step.
- Rounding:
  - From reset, a single sample -1 with ROUND=0 gives out_data = -1 (0xFF).
  - The same sample with ROUND=1 gives out_data = 0.
  - Samples 1, 1 with ROUND=1 give sum 2 -> out_data 1; with ROUND=0 they give 0.
- Gaps and wrap:
  - Apply in_valid as 1,0,1,1,0,1 with data 10, x, 20, 30, x, 40, then 50.
  - out_valid pulses only for the accepted samples.
  - On the 50 sample, 10 is evicted: sum_out = 140, out_data = 35.
- Clear collision:
  - In RUN, assert clear together with in_valid and data 100: the next cycle has out_valid = 0, full = 0, sum_out = 0.
  - A following sample of 8 gives sum_out = 8, out_data = 2.
- Asynchronous reset mid-stream:
  - Assert rst between clock edges while samples are streaming: all outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the ramp test reproduces exactly.
